// File: rtl/clock_divider_multi_pkg.sv
// Shared constants, channel state type and helpers for the multi-channel clock divider.
package clock_divider_multi_pkg;

   localparam int MIN_DIV = 2;

   typedef enum logic {
      CH_IDLE = 1'b0,
      CH_RUN  = 1'b1
   } ch_state_t;

   function automatic int ch_idx_width(input int num_ch);
      return (num_ch > 1) ? $clog2(num_ch) : 1;
   endfunction

   function automatic int default_high(input int div);
      return div / 2;
   endfunction

endpackage

// File: rtl/clock_div_channel.sv
// One divider channel: active/shadow divisor and high-count, wrap-aligned shadow transfer.
module clock_div_channel
   import clock_divider_multi_pkg::*;
#(
   parameter int WIDTH       = 28,
   parameter int DEFAULT_DIV = 10000
) (
   input  logic             clock_in,
   input  logic             reset,
   input  logic             enable,
   input  logic             wr,
   input  logic [WIDTH-1:0] wr_div,
   input  logic [WIDTH-1:0] wr_high,
   output logic             clock_out,
   output logic             tick,
   output logic             pending
);

   localparam logic [WIDTH-1:0] RST_DIV  = WIDTH'(DEFAULT_DIV);
   localparam logic [WIDTH-1:0] RST_HIGH = WIDTH'(default_high(DEFAULT_DIV));

   ch_state_t        state_q, state_d;
   logic [WIDTH-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] act_div_q, act_div_d, act_high_q, act_high_d;
   logic [WIDTH-1:0] sh_div_q, sh_div_d, sh_high_q, sh_high_d;
   logic             clk_d, tick_d, pend_d;
   logic             wrap, apply;

   always_comb begin
      state_d = state_q;
      case (state_q)
         CH_IDLE: if (enable)  state_d = CH_RUN;
         CH_RUN:  if (!enable) state_d = CH_IDLE;
         default: state_d = CH_IDLE;
      endcase
   end

   // The shadow may only land where a new period begins: at a wrap, at the
   // first enabled edge, or while the channel is stopped.
   assign wrap  = (state_q == CH_RUN) && (cnt_q == act_div_q - WIDTH'(1));
   assign apply = pending && (!enable || (state_q == CH_IDLE) || wrap);

   always_comb begin
      cnt_d      = cnt_q;
      clk_d      = clock_out;
      tick_d     = 1'b0;
      act_div_d  = act_div_q;
      act_high_d = act_high_q;
      sh_div_d   = sh_div_q;
      sh_high_d  = sh_high_q;
      pend_d     = pending;
      if (apply) begin
         act_div_d  = sh_div_q;
         act_high_d = sh_high_q;
         pend_d     = 1'b0;
      end
      if (!enable) begin
         cnt_d = '0;
         clk_d = 1'b0;
      end else if (state_q == CH_IDLE) begin
         cnt_d = '0;
         clk_d = (act_high_d != '0);
      end else begin
         cnt_d  = wrap ? '0 : cnt_q + WIDTH'(1);
         tick_d = wrap;
         clk_d  = (cnt_d < act_high_d);
      end
      // A same-edge write lands after the transfer so it stays pending.
      if (wr) begin
         sh_div_d  = wr_div;
         sh_high_d = wr_high;
         pend_d    = 1'b1;
      end
   end

   always_ff @(posedge clock_in) begin
      if (reset) begin
         state_q    <= CH_IDLE;
         cnt_q      <= '0;
         clock_out  <= 1'b0;
         tick       <= 1'b0;
         pending    <= 1'b0;
         act_div_q  <= RST_DIV;
         act_high_q <= RST_HIGH;
         sh_div_q   <= RST_DIV;
         sh_high_q  <= RST_HIGH;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         clock_out  <= clk_d;
         tick       <= tick_d;
         pending    <= pend_d;
         act_div_q  <= act_div_d;
         act_high_q <= act_high_d;
         sh_div_q   <= sh_div_d;
         sh_high_q  <= sh_high_d;
      end
   end

endmodule

// File: rtl/clock_divider_multi.sv
// Multi-channel programmable clock divider: write decode, error flag and NUM_CH channels.
module clock_divider_multi
   import clock_divider_multi_pkg::*;
#(
   parameter int WIDTH       = 28,
   parameter int NUM_CH      = 4,
   parameter int DEFAULT_DIV = 10000
) (
   input  logic                                clock_in,
   input  logic                                reset,
   input  logic [NUM_CH-1:0]                   enable,
   input  logic                                wr_en,
   input  logic [ch_idx_width(NUM_CH)-1:0]     wr_ch,
   input  logic [WIDTH-1:0]                    wr_div,
   input  logic [WIDTH-1:0]                    wr_high,
   output logic [NUM_CH-1:0]                   clock_out,
   output logic [NUM_CH-1:0]                   tick,
   output logic [NUM_CH-1:0]                   pending,
   output logic                                wr_err
);

   localparam int CH_W = ch_idx_width(NUM_CH);

   logic wr_ok;

   assign wr_ok = wr_en && (wr_div >= WIDTH'(MIN_DIV)) && (int'(wr_ch) < NUM_CH);

   always_ff @(posedge clock_in) begin
      if (reset) wr_err <= 1'b0;
      else       wr_err <= wr_en && !wr_ok;
   end

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      clock_div_channel #(
         .WIDTH       (WIDTH),
         .DEFAULT_DIV (DEFAULT_DIV)
      ) u_ch (
         .clock_in  (clock_in),
         .reset     (reset),
         .enable    (enable[i]),
         .wr        (wr_ok && (wr_ch == CH_W'(i))),
         .wr_div    (wr_div),
         .wr_high   (wr_high),
         .clock_out (clock_out[i]),
         .tick      (tick[i]),
         .pending   (pending[i])
      );
   end

endmodule

// File: tb/tb_clock_divider_multi.sv
// Bench for clock_divider_multi: per-edge comparison against a period-timing reference model.
module tb_clock_divider_multi;

   localparam int W    = 8;
   localparam int N    = 4;
   localparam int DDIV = 10;

   logic          clock_in = 1'b0;
   logic          reset;
   logic [N-1:0]  enable;
   logic          wr_en;
   logic [1:0]    wr_ch;
   logic [W-1:0]  wr_div, wr_high;
   logic [N-1:0]  clock_out, tick, pending;
   logic          wr_err;

   // Second instance with three channels, so an out-of-range index is encodable.
   logic [2:0]    enable_b;
   logic          wr_en_b;
   logic [1:0]    wr_ch_b;
   logic [W-1:0]  wr_div_b, wr_high_b;
   logic [2:0]    clock_out_b, tick_b, pending_b;
   logic          wr_err_b;

   clock_divider_multi #(.WIDTH(W), .NUM_CH(N), .DEFAULT_DIV(DDIV)) dut (
      .clock_in (clock_in), .reset (reset), .enable (enable), .wr_en (wr_en),
      .wr_ch (wr_ch), .wr_div (wr_div), .wr_high (wr_high),
      .clock_out (clock_out), .tick (tick), .pending (pending), .wr_err (wr_err)
   );

   clock_divider_multi #(.WIDTH(W), .NUM_CH(3), .DEFAULT_DIV(DDIV)) dut_b (
      .clock_in (clock_in), .reset (reset), .enable (enable_b), .wr_en (wr_en_b),
      .wr_ch (wr_ch_b), .wr_div (wr_div_b), .wr_high (wr_high_b),
      .clock_out (clock_out_b), .tick (tick_b), .pending (pending_b), .wr_err (wr_err_b)
   );

   always #5 clock_in = ~clock_in;

   int checks = 0;
   int errors = 0;

   // Reference model: each running channel remembers the edge at which its
   // current period began; a period ends after exactly div edges.
   int            m_div[N], m_high[N], m_sdiv[N], m_shigh[N], m_t0[N];
   bit            m_pend[N], m_run[N];
   int            edge_no = 0;
   logic [N-1:0]  e_clk, e_tick, e_pend;
   logic          e_err;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h at edge %0d", tag, obs, exp, edge_no);
      end
   endtask

   task automatic apply_shadow(input int ch);
      if (m_pend[ch]) begin
         m_div[ch]  = m_sdiv[ch];
         m_high[ch] = m_shigh[ch];
         m_pend[ch] = 1'b0;
      end
   endtask

   task automatic model_step();
      edge_no++;
      if (reset) begin
         for (int c = 0; c < N; c++) begin
            m_div[c] = DDIV;  m_high[c] = DDIV / 2;
            m_sdiv[c] = DDIV; m_shigh[c] = DDIV / 2;
            m_pend[c] = 1'b0; m_run[c] = 1'b0; m_t0[c] = 0;
         end
         e_clk = '0; e_tick = '0; e_pend = '0; e_err = 1'b0;
         return;
      end
      e_err = wr_en && ((int'(wr_div) < 2) || (int'(wr_ch) >= N));
      for (int c = 0; c < N; c++) begin
         e_tick[c] = 1'b0;
         if (!enable[c]) begin
            apply_shadow(c);
            m_run[c] = 1'b0;
            e_clk[c] = 1'b0;
         end else if (!m_run[c]) begin
            apply_shadow(c);
            m_run[c] = 1'b1;
            m_t0[c]  = edge_no;
            e_clk[c] = (m_high[c] > 0);
         end else begin
            if (edge_no - m_t0[c] == m_div[c]) begin
               m_t0[c]   = edge_no;
               apply_shadow(c);
               e_tick[c] = 1'b1;
            end
            e_clk[c] = ((edge_no - m_t0[c]) < m_high[c]);
         end
         if (wr_en && !e_err && (int'(wr_ch) == c)) begin
            m_sdiv[c]  = int'(wr_div);
            m_shigh[c] = int'(wr_high);
            m_pend[c]  = 1'b1;
         end
         e_pend[c] = m_pend[c];
      end
   endtask

   task automatic cycle();
      @(posedge clock_in);
      #1;
      model_step();
      check("clock_out", 32'(clock_out), 32'(e_clk));
      check("tick",      32'(tick),      32'(e_tick));
      check("pending",   32'(pending),   32'(e_pend));
      check("wr_err",    32'(wr_err),    32'(e_err));
   endtask

   task automatic run(input int n);
      for (int k = 0; k < n; k++) cycle();
   endtask

   task automatic write(input int ch, input int div, input int high);
      wr_en = 1'b1; wr_ch = 2'(ch); wr_div = W'(div); wr_high = W'(high);
      cycle();
      wr_en = 1'b0;
   endtask

   initial begin
      bit found;
      reset = 1'b1; enable = '0; wr_en = 1'b0; wr_ch = '0; wr_div = '0; wr_high = '0;
      enable_b = '0; wr_en_b = 1'b0; wr_ch_b = '0; wr_div_b = '0; wr_high_b = '0;

      // reset state, then a single channel at the default divisor
      run(2);
      reset = 1'b0;
      run(2);
      enable[0] = 1'b1;
      run(32);

      // mid-period reconfiguration of ch1
      enable = 4'hF;
      run(7);
      write(1, 6, 2);
      run(24);

      // rejected writes leave ch0 at period 10
      write(0, 1, 0);
      write(0, 0, 3);
      run(22);

      // high==0 then high>=div on ch2
      write(2, 10, 0);
      run(25);
      write(2, 10, 12);
      run(25);

      // write landing exactly on ch3's wrap edge while a shadow is pending
      write(3, 7, 3);
      found = 1'b0;
      for (int k = 0; k < 30 && !found; k++) begin
         if (m_run[3] && m_pend[3] && (edge_no + 1 - m_t0[3] == m_div[3])) found = 1'b1;
         else cycle();
      end
      checks++;
      assert (found === 1'b1) else begin
         errors++;
         $error("FAIL ch3_wrap_search observed=%0d expected=1", found);
      end
      write(3, 5, 1);
      run(20);

      // disabled channel applies its shadow on the next edge
      enable[2] = 1'b0;
      write(2, 4, 1);
      run(3);
      enable[2] = 1'b1;
      run(12);

      // reset mid-period with writes pending
      write(1, 9, 4);
      write(0, 8, 8);
      run(3);
      reset = 1'b1;
      wr_en = 1'b1; wr_ch = 2'd2; wr_div = 8'd3; wr_high = 8'd1;
      cycle();
      wr_en = 1'b0;
      reset = 1'b0;
      run(25);

      // randomized traffic
      for (int k = 0; k < 450; k++) begin
         if ($urandom_range(0, 7) == 0) enable[$urandom_range(0, N - 1)] ^= 1'b1;
         if ($urandom_range(0, 5) == 0) begin
            wr_en = 1'b1; wr_ch = 2'($urandom_range(0, N - 1));
            wr_div = W'($urandom_range(0, 12)); wr_high = W'($urandom_range(0, 14));
         end
         if ($urandom_range(0, 199) == 0) reset = 1'b1;
         cycle();
         wr_en = 1'b0; reset = 1'b0;
      end

      // three-channel instance: index 3 is out of range
      wr_en_b = 1'b1; wr_ch_b = 2'd3; wr_div_b = 8'd8; wr_high_b = 8'd2;
      cycle();
      check("b_wr_err_range", 32'(wr_err_b), 32'd1);
      check("b_pending_range", 32'(pending_b), 32'd0);
      wr_ch_b = 2'd2;
      cycle();
      check("b_wr_err_valid", 32'(wr_err_b), 32'd0);
      check("b_pending_valid", 32'(pending_b), 32'b100);
      wr_ch_b = 2'd0; wr_div_b = 8'd1;
      cycle();
      check("b_wr_err_div", 32'(wr_err_b), 32'd1);
      check("b_pending_applied", 32'(pending_b), 32'd0);
      wr_en_b = 1'b0;
      cycle();
      check("b_wr_err_clear", 32'(wr_err_b), 32'd0);
      check("b_idle_outputs", 32'({clock_out_b, tick_b}), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
